// File: rtl/fighter_pkg.sv
// Shared types and constants for the fighter animation sequencer:
// state encoding, sprite pose indices and per-action pose counts.
package fighter_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WALK,
    S_KICK,
    S_PUNCH,
    S_JUMP,
    S_DODGE
  } fighter_state_t;

  localparam logic [3:0] SPR_IDLE   = 4'd0;
  localparam logic [3:0] SPR_WALK0  = 4'd1;
  localparam logic [3:0] SPR_WALK1  = 4'd2;
  localparam logic [3:0] SPR_KICK0  = 4'd3;
  localparam logic [3:0] SPR_KICK1  = 4'd4;
  localparam logic [3:0] SPR_KICK2  = 4'd5;
  localparam logic [3:0] SPR_PUNCH0 = 4'd6;
  localparam logic [3:0] SPR_PUNCH1 = 4'd7;
  localparam logic [3:0] SPR_JUMP   = 4'd8;
  localparam logic [3:0] SPR_DODGE0 = 4'd9;
  localparam logic [3:0] SPR_DODGE1 = 4'd10;

  localparam int KICK_POSES  = 3;
  localparam int PUNCH_POSES = 2;
  localparam int DODGE_POSES = 2;

  // Only the middle kick pose and the second punch pose can land a hit.
  function automatic logic is_attack_pose(input logic [3:0] spr);
    return (spr == SPR_KICK1) || (spr == SPR_PUNCH1);
  endfunction

  function automatic logic [1:0] pose_last(input fighter_state_t s);
    logic [1:0] last;
    last = 2'd0;
    case (s)
      S_KICK:  last = 2'(KICK_POSES - 1);
      S_PUNCH: last = 2'(PUNCH_POSES - 1);
      S_DODGE: last = 2'(DODGE_POSES - 1);
      default: last = 2'd0;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/anim_hold_timer.sv
// Counts frame ticks within the current pose; pulses pose_advance on the
// tick that completes HOLD_FRAMES ticks since the last restart.
module anim_hold_timer #(
  parameter int HOLD_FRAMES = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_tick,
  input  logic restart,
  output logic pose_advance
);

  localparam int CW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  logic [CW-1:0] cnt_reg;
  logic          at_last;

  assign at_last      = (cnt_reg == CW'(HOLD_FRAMES - 1));
  assign pose_advance = frame_tick && !restart && at_last;

  // A restart tick is itself the first tick of the new pose.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_reg <= '0;
    end else if (restart) begin
      cnt_reg <= '0;
    end else if (frame_tick) begin
      cnt_reg <= at_last ? '0 : cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/fighter_anim_seq.sv
// Frame-paced fighter animation sequencer: pose, position, jump height,
// facing and attack window. Define FIGHTER_AIR_CONTROL_EN for mid-air steering.
module fighter_anim_seq
  import fighter_pkg::*;
#(
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 590,
  parameter int X_START     = 100,
  parameter int STEP        = 2,
  parameter int HOLD_FRAMES = 4,
  parameter int JUMP_H      = 32,
  parameter int JUMP_STEP   = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       stand_left,
  input  logic       stand_right,
  input  logic       left,
  input  logic       right,
  input  logic       kick,
  input  logic       fight,
  input  logic       jump,
  input  logic       dodge,
  output logic [3:0] sprite_id,
  output logic [9:0] pos_x,
  output logic [7:0] jump_y,
  output logic       facing_left,
  output logic       busy,
  output logic       attack_active
);

  fighter_state_t state_reg;
  fighter_state_t sel_state;
  logic [1:0]     pose_idx_reg;
  logic           rising_reg;
  logic           walk_req;
  logic           restart;
  logic           pose_advance;

  function automatic logic [9:0] step_x(input logic [9:0] x, input logic go_left);
    int nx;
    nx = go_left ? int'(x) - STEP : int'(x) + STEP;
    if (nx < X_MIN) nx = X_MIN;
    if (nx > X_MAX) nx = X_MAX;
    return 10'(nx);
  endfunction

  assign walk_req = left ^ right;

  always_comb begin
    sel_state = S_IDLE;
    if (jump)          sel_state = S_JUMP;
    else if (kick)     sel_state = S_KICK;
    else if (fight)    sel_state = S_PUNCH;
    else if (dodge)    sel_state = S_DODGE;
    else if (walk_req) sel_state = S_WALK;
  end

  // Continuing a walk keeps the pose timer running so the stride alternates.
  assign restart = frame_tick
                && ((state_reg == S_IDLE) || (state_reg == S_WALK))
                && !((state_reg == S_WALK) && (sel_state == S_WALK));

  anim_hold_timer #(
    .HOLD_FRAMES(HOLD_FRAMES)
  ) u_hold_timer (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_tick  (frame_tick),
    .restart     (restart),
    .pose_advance(pose_advance)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg     <= S_IDLE;
      pose_idx_reg  <= 2'd0;
      rising_reg    <= 1'b1;
      sprite_id     <= SPR_IDLE;
      pos_x         <= 10'(X_START);
      jump_y        <= 8'd0;
      facing_left   <= 1'b0;
      busy          <= 1'b0;
      attack_active <= 1'b0;
    end else begin
      if (stand_left && !stand_right) begin
        facing_left <= 1'b1;
      end else if (!stand_left && stand_right) begin
        facing_left <= 1'b0;
      end

      if (frame_tick) begin
        unique case (state_reg)
          S_IDLE, S_WALK: begin
            state_reg     <= sel_state;
            pose_idx_reg  <= 2'd0;
            rising_reg    <= 1'b1;
            attack_active <= 1'b0;
            case (sel_state)
              S_JUMP: begin
                sprite_id <= SPR_JUMP;
                busy      <= 1'b1;
              end
              S_KICK: begin
                sprite_id <= SPR_KICK0;
                busy      <= 1'b1;
              end
              S_PUNCH: begin
                sprite_id <= SPR_PUNCH0;
                busy      <= 1'b1;
              end
              S_DODGE: begin
                sprite_id <= SPR_DODGE0;
                busy      <= 1'b1;
              end
              S_WALK: begin
                busy  <= 1'b0;
                pos_x <= step_x(pos_x, left);
                if (state_reg != S_WALK) begin
                  sprite_id <= SPR_WALK0;
                end else if (pose_advance) begin
                  sprite_id <= (sprite_id == SPR_WALK0) ? SPR_WALK1 : SPR_WALK0;
                end
              end
              default: begin
                sprite_id <= SPR_IDLE;
                busy      <= 1'b0;
              end
            endcase
          end

          S_KICK, S_PUNCH, S_DODGE: begin
            if (pose_advance) begin
              if (pose_idx_reg == pose_last(state_reg)) begin
                state_reg     <= S_IDLE;
                pose_idx_reg  <= 2'd0;
                sprite_id     <= SPR_IDLE;
                busy          <= 1'b0;
                attack_active <= 1'b0;
              end else begin
                // Poses of one action use consecutive sprite indices.
                pose_idx_reg  <= pose_idx_reg + 2'd1;
                sprite_id     <= sprite_id + 4'd1;
                attack_active <= is_attack_pose(sprite_id + 4'd1);
              end
            end
          end

          S_JUMP: begin
`ifdef FIGHTER_AIR_CONTROL_EN
            if (walk_req) begin
              pos_x <= step_x(pos_x, left);
            end
`endif
            if (rising_reg) begin
              if (int'(jump_y) + JUMP_STEP >= JUMP_H) begin
                jump_y     <= 8'(JUMP_H);
                rising_reg <= 1'b0;
              end else begin
                jump_y <= jump_y + 8'(JUMP_STEP);
              end
            end else if (int'(jump_y) <= JUMP_STEP) begin
              jump_y     <= 8'd0;
              rising_reg <= 1'b1;
              state_reg  <= S_IDLE;
              sprite_id  <= SPR_IDLE;
              busy       <= 1'b0;
            end else begin
              jump_y <= jump_y - 8'(JUMP_STEP);
            end
          end

          default: begin
            state_reg <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fighter_anim_seq.sv
// Scoreboard bench for fighter_anim_seq: expected outputs are queued per
// frame tick and compared one cycle after the tick edge.
module tb_fighter_anim_seq;

  logic       Clk;
  logic       Reset;
  logic       frame_tick;
  logic       stand_left, stand_right;
  logic       left, right, kick, fight, jump, dodge;
  logic [3:0] sprite_id;
  logic [9:0] pos_x;
  logic [7:0] jump_y;
  logic       facing_left, busy, attack_active;

  typedef struct {
    int spr;
    int px;
    int jy;
    int bsy;
    int atk;
    int fl;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   errors;
  int   model_fl;

  fighter_anim_seq dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_tick   (frame_tick),
    .stand_left   (stand_left),
    .stand_right  (stand_right),
    .left         (left),
    .right        (right),
    .kick         (kick),
    .fight        (fight),
    .jump         (jump),
    .dodge        (dodge),
    .sprite_id    (sprite_id),
    .pos_x        (pos_x),
    .jump_y       (jump_y),
    .facing_left  (facing_left),
    .busy         (busy),
    .attack_active(attack_active)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input int spr, input int px, input int jy,
                              input int bsy, input int atk);
    exp_t e;
    e.spr = spr; e.px = px; e.jy = jy; e.bsy = bsy; e.atk = atk; e.fl = model_fl;
    return e;
  endfunction

  task automatic compare_all(input string tag, input exp_t e);
    check_val({tag, ".sprite"}, int'(sprite_id), e.spr);
    check_val({tag, ".pos_x"},  int'(pos_x),     e.px);
    check_val({tag, ".jump_y"}, int'(jump_y),    e.jy);
    check_val({tag, ".busy"},   int'(busy),      e.bsy);
    check_val({tag, ".attack"}, int'(attack_active), e.atk);
    check_val({tag, ".facing"}, int'(facing_left),   e.fl);
  endtask

  // One frame tick: queue the expectation, pulse the tick, compare, then
  // confirm nothing moves during the idle cycles before the next tick.
  task automatic do_tick(input string tag, input exp_t e);
    exp_t got_e;
    sb_q.push_back(e);
    @(negedge Clk);
    frame_tick = 1'b1;
    @(posedge Clk);
    #1;
    frame_tick = 1'b0;
    got_e = sb_q.pop_front();
    compare_all(tag, got_e);
    $display("tick %s sprite=%0d pos_x=%0d jump_y=%0d busy=%0d atk=%0d",
             tag, sprite_id, pos_x, jump_y, busy, attack_active);
    repeat (2) @(posedge Clk);
    #1;
    check_val({tag, ".hold_sprite"}, int'(sprite_id), got_e.spr);
    check_val({tag, ".hold_pos"},    int'(pos_x),     got_e.px);
  endtask

  task automatic facing_step(input string tag, input logic sl, input logic sr, input int want);
    @(negedge Clk);
    stand_left  = sl;
    stand_right = sr;
    @(posedge Clk);
    #1;
    model_fl = want;
    check_val(tag, int'(facing_left), want);
    $display("facing %s stand_left=%0d stand_right=%0d facing_left=%0d", tag, sl, sr, facing_left);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int px;
    int j;
    checks = 0; errors = 0; model_fl = 0;
    Reset = 1'b1; frame_tick = 1'b0;
    stand_left = 1'b0; stand_right = 1'b0;
    left = 0; right = 0; kick = 0; fight = 0; jump = 0; dodge = 0;
    repeat (3) @(posedge Clk);
    #1;
    compare_all("reset", mk(0, 100, 0, 0, 0));
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 5; i++) do_tick("idle", mk(0, 100, 0, 0, 0));

    // Kick: three poses of four ticks; a punch request mid-kick is ignored.
    kick = 1;
    do_tick("kick0", mk(3, 100, 0, 1, 0));
    kick = 0;
    for (int t = 1; t < 12; t++) begin
      fight = (t == 6);
      do_tick("kick", mk(3 + t / 4, 100, 0, 1, (t / 4 == 1) ? 1 : 0));
    end
    fight = 0;
    do_tick("kick_end", mk(0, 100, 0, 0, 0));
    do_tick("kick_after", mk(0, 100, 0, 0, 0));

    // Walk right ten ticks, then release.
    right = 1;
    for (int t = 0; t < 10; t++)
      do_tick("walk", mk(((t / 4) % 2) ? 2 : 1, 100 + 2 * (t + 1), 0, 0, 0));
    right = 0;
    do_tick("walk_rel", mk(0, 120, 0, 0, 0));

    // Walk to the right limit and saturate there.
    right = 1;
    for (int t = 0; t < 237; t++) begin
      px = 120 + 2 * (t + 1);
      if (px > 590) px = 590;
      do_tick((t >= 233) ? "walk_sat" : "walk_far",
              mk(((t / 4) % 2) ? 2 : 1, px, 0, 0, 0));
    end
    left = 1;
    do_tick("both_walk", mk(0, 590, 0, 0, 0));
    do_tick("both_walk2", mk(0, 590, 0, 0, 0));
    right = 0;
    left = 0;

    // Jump with left held for the whole flight.
    jump = 1;
    do_tick("jump0", mk(8, 590, 0, 1, 0));
    jump = 0;
    left = 1;
    for (int t = 1; t <= 16; t++) begin
      j = (t <= 8) ? 4 * t : 4 * (16 - t);
`ifdef FIGHTER_AIR_CONTROL_EN
      px = 590 - 2 * t;
`else
      px = 590;
`endif
      if (t < 16) do_tick("jump", mk(8, px, j, 1, 0));
      else        do_tick("jump_end", mk(0, px, 0, 0, 0));
    end
    left = 0;
    do_tick("jump_after", mk(0, px, 0, 0, 0));

    // Facing follows the control FSM every clock; ambiguous inputs hold.
    facing_step("face_left", 1'b1, 1'b0, 1);
    facing_step("face_both", 1'b1, 1'b1, 1);
    facing_step("face_none", 1'b0, 1'b0, 1);
    facing_step("face_right", 1'b0, 1'b1, 0);
    facing_step("face_clear", 1'b0, 1'b0, 0);

    // Reset in the middle of the attack window.
    kick = 1;
    do_tick("rkick0", mk(3, px, 0, 1, 0));
    kick = 0;
    for (int t = 1; t <= 4; t++)
      do_tick("rkick", mk(3 + t / 4, px, 0, 1, (t / 4 == 1) ? 1 : 0));
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    compare_all("mid_reset", mk(0, 100, 0, 0, 0));
    @(negedge Clk);
    Reset = 1'b0;
    do_tick("post_reset", mk(0, 100, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fighter_anim_seq.md
Name: fighter_anim_seq

Overview:
Downstream consumer of the fighter control state machine's facing outputs (stand_left/stand_right) and the raw action requests. It turns them into a frame-paced animation sequence: sprite pose index, horizontal position, jump height, facing and attack window. Its outputs feed the sprite renderer and the hit detector. All pacing is driven by a one-cycle frame_tick from the video timing block.

Parameters:
X_MIN, 0, left position limit (pixels)
X_MAX, 590, right position limit (pixels)
X_START, 100, pos_x after reset
STEP, 2, pixels moved per frame_tick while walking
HOLD_FRAMES, 4, frame_ticks per animation pose (>=1)
JUMP_H, 32, peak jump_y; must be a multiple of JUMP_STEP
JUMP_STEP, 4, jump_y change per frame_tick

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame
stand_left  in  1  facing-left indication from the control FSM
stand_right  in  1  facing-right indication from the control FSM
left, right  in  1 each  walk requests (levels)
kick, fight, jump, dodge  in  1 each  action requests (levels)
sprite_id  out  4  pose index to the renderer
pos_x  out  10  horizontal position
jump_y  out  8  vertical offset above ground
facing_left  out  1  1 = sprite mirrored to face left
busy  out  1  non-interruptible action in progress
attack_active  out  1  hit window for the hit detector

Behaviour:
- Reset: the block is reset by Reset (asynchronous, active-high) and clocked by Clk. On reset: state IDLE, sprite_id=0, pos_x=X_START, jump_y=0, facing_left=0, busy=0, attack_active=0, counters=0.
- Registered outputs:
  - All outputs are registered.
  - Requests are sampled only on an edge where frame_tick=1; the result is visible the following cycle.
  - No activity happens between ticks.
- Facing: updated every clock.
  - stand_left=1, stand_right=0 -> facing_left=1.
  - stand_left=0, stand_right=1 -> facing_left=0.
  - Both 0 -> hold. Both 1 -> hold (illegal upstream).
- States: IDLE, WALK, KICK, PUNCH, JUMP, DODGE.
- Request selection in IDLE/WALK, on a tick, priority jump > kick > fight > dodge > walk:
  - jump -> JUMP.
  - kick -> KICK.
  - fight -> PUNCH.
  - dodge -> DODGE.
  - Exactly one of left/right -> WALK.
  - Otherwise -> IDLE. left and right together count as no walk.
- WALK:
  - Each tick pos_x moves by STEP (left: minus, right: plus), saturating at X_MIN/X_MAX, no wrap.
  - sprite_id alternates 1/2 every HOLD_FRAMES ticks, starting at 1.
  - If the walk request is released, next tick goes to IDLE, sprite 0.
- KICK:
  - Poses 3,4,5, each held HOLD_FRAMES ticks.
  - attack_active=1 exactly while sprite_id=4.
- PUNCH:
  - Poses 6,7, each held HOLD_FRAMES ticks.
  - attack_active=1 while sprite_id=7.
- DODGE: poses 9,10, each held HOLD_FRAMES ticks.
- JUMP:
  - sprite_id=8.
  - jump_y rises by JUMP_STEP per tick until it reaches JUMP_H, then falls by JUMP_STEP per tick to 0.
  - Exits on the tick where jump_y reaches 0.
- KICK/PUNCH/DODGE/JUMP:
  - busy=1 throughout.
  - All requests are ignored while busy.
  - On completion, return to IDLE (sprite 0) on the tick that ends the last pose. New requests are accepted from the next tick.
- Reset mid-action: immediate abort to reset values.

Optional Feature:
Macro: FIGHTER_AIR_CONTROL_EN.
- Defined: during JUMP, left/right (exactly one) move pos_x by STEP per tick with the same saturation. sprite_id stays 8.
- Undefined: pos_x is frozen during JUMP.

Decomposition:
- Package fighter_pkg holds:
  - the state enum;
  - sprite ID constants (SPR_IDLE=0, SPR_WALK0/1=1/2, SPR_KICK0..2=3..5, SPR_PUNCH0/1=6/7, SPR_JUMP=8, SPR_DODGE0/1=9/10);
  - the pose-count constants.
- Sub-module anim_hold_timer (inputs: frame_tick, restart; output: pose_advance pulse every HOLD_FRAMES ticks) is used by the main FSM.

Test Plan:
- Reset, then 5 ticks with no requests -> sprite_id=0, pos_x=100, jump_y=0, facing_left=0, busy=0.
- kick held for 1 tick, HOLD_FRAMES=4 -> sprite 3 for 4 ticks, 4 for 4 ticks (attack_active=1), 5 for 4 ticks, then sprite 0 and busy=0 after tick 12; fight asserted at tick 6 ignored.
- right held for 10 ticks from pos_x=100 -> pos_x=120, sprite sequence 1,1,1,1,2,2,2,2,1,1; release -> sprite 0.
- pos_x=588 with right held for 3 ticks -> 590, 590, 590. left+right together -> IDLE, no motion.
- jump with JUMP_H=32, JUMP_STEP=4 -> jump_y 4..32 peaks at tick 8, 0 at tick 16, then IDLE. With the macro undefined and left held, pos_x is unchanged; with it defined, pos_x decreases by 32.
- Reset pulse at tick 5 of a kick -> next cycle sprite_id=0, pos_x=100, busy=0, attack_active=0. stand_left=1/stand_right=0 -> facing_left=1 one cycle later.
